// File: rtl/signal_phase_scheduler.sv
// Traffic-signal phase scheduler: main/cross road phases driven by a 1 Hz tick,
// with emergency-vehicle hold, police all-red override and flashing-yellow off mode.
`timescale 1ns/1ps
module signal_phase_scheduler (
  input  logic       clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       Online,
  input  logic       Peaks,
  input  logic [1:0] CarRatio,
  input  logic       Police,
  input  logic       AV,
  input  logic       Cm,
  input  logic       Cc,
  input  logic       PQm,
  input  logic       PQc,
  output logic       main_g,
  output logic       main_y,
  output logic       main_r,
  output logic       sub_g,
  output logic       sub_y,
  output logic       sub_r,
  output logic       walk_m,
  output logic       walk_c,
  output logic [2:0] state,
  output logic [7:0] count
);
  localparam logic [7:0] T_Y      = 8'd3;
  localparam logic [7:0] T_AR     = 8'd2;
  localparam logic [7:0] T_SG     = 8'd20;
  localparam logic [7:0] T_SG_MIN = 8'd5;

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_MG = 3'd1, S_MY = 3'd2, S_AR1 = 3'd3,
    S_SG  = 3'd4, S_SY = 3'd5, S_AR2 = 3'd6, S_POL = 3'd7
  } phase_t;

  phase_t     state_reg;
  logic [7:0] count_reg;
  logic       blink_reg;
  logic       pend_m_reg;
  logic       pend_c_reg;
  logic [7:0] t_mg;
  logic       last_tick;
  logic       unused_inputs;

  // Main-green length is taken from the load inputs at the moment MG is entered.
  assign t_mg          = 8'd30 + 8'd10 * {6'd0, CarRatio} + (Peaks ? 8'd20 : 8'd0);
  assign last_tick     = (count_reg <= 8'd1);
  assign unused_inputs = Cm;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg  <= S_OFF;
      count_reg  <= 8'd0;
      blink_reg  <= 1'b0;
      pend_m_reg <= 1'b0;
      pend_c_reg <= 1'b0;
    end else begin
      pend_m_reg <= pend_m_reg | PQm;
      pend_c_reg <= pend_c_reg | PQc;
      blink_reg  <= 1'b0;
      if (!Online) begin
        state_reg <= S_OFF;
        count_reg <= 8'd0;
        blink_reg <= (state_reg == S_OFF) & (blink_reg ^ tick);
      end else if (Police) begin
        state_reg <= S_POL;
        count_reg <= 8'd0;
      end else begin
        case (state_reg)
          S_OFF, S_POL: begin
            state_reg <= S_AR2;
            count_reg <= T_AR;
          end
          S_MG: begin
            // AV freezes the countdown; at count 1 MG rests until a cross demand exists.
            if (tick && !AV) begin
              if (!last_tick) count_reg <= count_reg - 8'd1;
              else if (Cc || pend_c_reg) begin
                state_reg <= S_MY;
                count_reg <= T_Y;
              end
            end
          end
          S_MY: begin
            if (tick) begin
              if (!last_tick) count_reg <= count_reg - 8'd1;
              else begin
                state_reg <= S_AR1;
                count_reg <= T_AR;
              end
            end
          end
          S_AR1: begin
            if (tick) begin
              if (!last_tick) count_reg <= count_reg - 8'd1;
              else if (AV) begin
                state_reg  <= S_MG;
                count_reg  <= t_mg;
                pend_m_reg <= PQm;
              end else begin
                state_reg  <= S_SG;
                count_reg  <= T_SG;
                pend_c_reg <= PQc;
              end
            end
          end
          S_SG: begin
            if (AV) begin
              state_reg <= S_SY;
              count_reg <= T_Y;
            end else if (tick) begin
              if (last_tick || (count_reg <= (T_SG - T_SG_MIN) && (!Cc || pend_m_reg))) begin
                state_reg <= S_SY;
                count_reg <= T_Y;
              end else begin
                count_reg <= count_reg - 8'd1;
              end
            end
          end
          S_SY: begin
            if (tick) begin
              if (!last_tick) count_reg <= count_reg - 8'd1;
              else begin
                state_reg <= S_AR2;
                count_reg <= T_AR;
              end
            end
          end
          S_AR2: begin
            if (tick) begin
              if (!last_tick) count_reg <= count_reg - 8'd1;
              else begin
                state_reg  <= S_MG;
                count_reg  <= t_mg;
                pend_m_reg <= PQm;
              end
            end
          end
          default: begin
            state_reg <= S_OFF;
            count_reg <= 8'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    main_g = 1'b0; main_y = 1'b0; main_r = 1'b0;
    sub_g  = 1'b0; sub_y  = 1'b0; sub_r  = 1'b0;
    walk_m = 1'b0; walk_c = 1'b0;
    case (state_reg)
      S_MG:  begin main_g = 1'b1; sub_r = 1'b1; walk_m = 1'b1; end
      S_MY:  begin main_y = 1'b1; sub_r = 1'b1; end
      S_SG:  begin sub_g = 1'b1; main_r = 1'b1; walk_c = 1'b1; end
      S_SY:  begin sub_y = 1'b1; main_r = 1'b1; end
      S_OFF: begin main_y = blink_reg; sub_y = blink_reg; end
      default: begin main_r = 1'b1; sub_r = 1'b1; end
    endcase
  end

  assign state = state_reg;
  assign count = count_reg;
endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Directed bench for signal_phase_scheduler: walks the phase sequence, rest, gap-out,
// emergency, police, off-mode and reset scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_signal_phase_scheduler;
  logic       clk = 1'b0;
  logic       Reset = 1'b1, tick = 1'b0, Online = 1'b0, Peaks = 1'b0;
  logic [1:0] CarRatio = 2'd0;
  logic       Police = 1'b0, AV = 1'b0, Cm = 1'b0, Cc = 1'b0, PQm = 1'b0, PQc = 1'b0;
  logic       main_g, main_y, main_r, sub_g, sub_y, sub_r, walk_m, walk_c;
  logic [2:0] state;
  logic [7:0] count;
  logic [7:0] lamps;
  int n_tests = 0;
  int n_fail  = 0;

  signal_phase_scheduler dut (
    .clk(clk), .Reset(Reset), .tick(tick), .Online(Online), .Peaks(Peaks),
    .CarRatio(CarRatio), .Police(Police), .AV(AV), .Cm(Cm), .Cc(Cc),
    .PQm(PQm), .PQc(PQc),
    .main_g(main_g), .main_y(main_y), .main_r(main_r),
    .sub_g(sub_g), .sub_y(sub_y), .sub_r(sub_r),
    .walk_m(walk_m), .walk_c(walk_c), .state(state), .count(count)
  );

  always #5 clk = ~clk;
  assign lamps = {main_g, main_y, main_r, sub_g, sub_y, sub_r, walk_m, walk_c};

  // One clock edge with the given tick value; outputs are stable at the following negedge.
  task automatic cyc(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    cyc(1'b1);
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd0, 8'd0}) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d want 0/0", state, count);
    end
    n_tests++;
    if (lamps !== 8'h00) begin
      n_fail++; $display("FAIL reset_lamps: got %b want 00000000", lamps);
    end
    Reset = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_normal_cycle;
    Online = 1'b1; CarRatio = 2'd1; Peaks = 1'b0; Cc = 1'b1;
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd6, 8'd2}) begin
      n_fail++; $display("FAIL online_ar2: got %0d/%0d want 6/2", state, count);
    end
    n_tests++;
    if (lamps !== 8'b00100100) begin
      n_fail++; $display("FAIL ar2_lamps: got %b want 00100100", lamps);
    end
    ticks(2);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd40}) begin
      n_fail++; $display("FAIL mg_entry: got %0d/%0d want 1/40", state, count);
    end
    n_tests++;
    if (lamps !== 8'b10000110) begin
      n_fail++; $display("FAIL mg_lamps: got %b want 10000110", lamps);
    end
    cyc(1'b0);
    n_tests++;
    if (count !== 8'd40) begin
      n_fail++; $display("FAIL no_tick_hold: got %0d want 40", count);
    end
    ticks(40);
    n_tests++;
    if ({state, count} !== {3'd2, 8'd3}) begin
      n_fail++; $display("FAIL my_entry: got %0d/%0d want 2/3", state, count);
    end
    n_tests++;
    if (lamps !== 8'b01000100) begin
      n_fail++; $display("FAIL my_lamps: got %b want 01000100", lamps);
    end
    ticks(3);
    n_tests++;
    if ({state, count} !== {3'd3, 8'd2}) begin
      n_fail++; $display("FAIL ar1_entry: got %0d/%0d want 3/2", state, count);
    end
    ticks(2);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd20}) begin
      n_fail++; $display("FAIL sg_entry: got %0d/%0d want 4/20", state, count);
    end
    n_tests++;
    if (lamps !== 8'b00110001) begin
      n_fail++; $display("FAIL sg_lamps: got %b want 00110001", lamps);
    end
    ticks(19);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd1}) begin
      n_fail++; $display("FAIL sg_no_gap: got %0d/%0d want 4/1", state, count);
    end
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd5, 8'd3}) begin
      n_fail++; $display("FAIL sy_entry: got %0d/%0d want 5/3", state, count);
    end
    n_tests++;
    if (lamps !== 8'b00101000) begin
      n_fail++; $display("FAIL sy_lamps: got %b want 00101000", lamps);
    end
    ticks(5);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd40}) begin
      n_fail++; $display("FAIL mg_again: got %0d/%0d want 1/40", state, count);
    end
    $display("[TB] test_normal_cycle done");
  endtask

  task automatic test_mg_rest_and_gap;
    Cc = 1'b0;
    ticks(44);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd1}) begin
      n_fail++; $display("FAIL mg_rest: got %0d/%0d want 1/1", state, count);
    end
    PQc = 1'b1; cyc(1'b0); PQc = 1'b0;
    n_tests++;
    if ({state, count} !== {3'd1, 8'd1}) begin
      n_fail++; $display("FAIL pqc_no_tick: got %0d/%0d want 1/1", state, count);
    end
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd2, 8'd3}) begin
      n_fail++; $display("FAIL pqc_exit: got %0d/%0d want 2/3", state, count);
    end
    ticks(5);
    ticks(4);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd16}) begin
      n_fail++; $display("FAIL sg_16: got %0d/%0d want 4/16", state, count);
    end
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd15}) begin
      n_fail++; $display("FAIL sg_16_no_exit: got %0d/%0d want 4/15", state, count);
    end
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd5, 8'd3}) begin
      n_fail++; $display("FAIL sg_gap_out: got %0d/%0d want 5/3", state, count);
    end
    $display("[TB] test_mg_rest_and_gap done");
  endtask

  task automatic test_av;
    Peaks = 1'b1; CarRatio = 2'd3; Cc = 1'b1;
    ticks(5);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd80}) begin
      n_fail++; $display("FAIL mg_max: got %0d/%0d want 1/80", state, count);
    end
    ticks(80 + 5 + 8);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd12}) begin
      n_fail++; $display("FAIL sg_12: got %0d/%0d want 4/12", state, count);
    end
    AV = 1'b1; Peaks = 1'b0; CarRatio = 2'd0;
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd5, 8'd3}) begin
      n_fail++; $display("FAIL av_sg_to_sy: got %0d/%0d want 5/3", state, count);
    end
    ticks(3);
    n_tests++;
    if ({state, count} !== {3'd6, 8'd2}) begin
      n_fail++; $display("FAIL av_ar2: got %0d/%0d want 6/2", state, count);
    end
    ticks(2 + 5);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd30}) begin
      n_fail++; $display("FAIL av_hold: got %0d/%0d want 1/30", state, count);
    end
    AV = 1'b0;
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd29}) begin
      n_fail++; $display("FAIL av_release: got %0d/%0d want 1/29", state, count);
    end
    ticks(29 + 3);
    AV = 1'b1;
    ticks(2);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd30}) begin
      n_fail++; $display("FAIL av_ar1_to_mg: got %0d/%0d want 1/30", state, count);
    end
    AV = 1'b0;
    $display("[TB] test_av done");
  endtask

  task automatic test_police;
    Police = 1'b1;
    cyc(1'b0);
    ticks(3);
    n_tests++;
    if ({state, count} !== {3'd7, 8'd0}) begin
      n_fail++; $display("FAIL pol_hold: got %0d/%0d want 7/0", state, count);
    end
    n_tests++;
    if (lamps !== 8'b00100100) begin
      n_fail++; $display("FAIL pol_lamps: got %b want 00100100", lamps);
    end
    Police = 1'b0;
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd6, 8'd2}) begin
      n_fail++; $display("FAIL pol_exit: got %0d/%0d want 6/2", state, count);
    end
    ticks(2);
    n_tests++;
    if ({state, count} !== {3'd1, 8'd30}) begin
      n_fail++; $display("FAIL pol_to_mg: got %0d/%0d want 1/30", state, count);
    end
    $display("[TB] test_police done");
  endtask

  task automatic test_offline_and_reset;
    ticks(30 + 3 + 2);
    AV = 1'b1; cyc(1'b0); AV = 1'b0;
    n_tests++;
    if ({state, count} !== {3'd5, 8'd3}) begin
      n_fail++; $display("FAIL pre_off_sy: got %0d/%0d want 5/3", state, count);
    end
    Online = 1'b0;
    cyc(1'b0);
    n_tests++;
    if ({state, count, lamps} !== {3'd0, 8'd0, 8'h00}) begin
      n_fail++; $display("FAIL off_entry: got %0d/%0d/%b want 0/0/00000000", state, count, lamps);
    end
    ticks(1);
    cyc(1'b0);
    n_tests++;
    if (lamps !== 8'b01001000) begin
      n_fail++; $display("FAIL blink_on: got %b want 01001000", lamps);
    end
    ticks(1);
    n_tests++;
    if (lamps !== 8'h00) begin
      n_fail++; $display("FAIL blink_off: got %b want 00000000", lamps);
    end
    Online = 1'b1; Police = 1'b1;
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd7, 8'd0}) begin
      n_fail++; $display("FAIL off_to_pol: got %0d/%0d want 7/0", state, count);
    end
    Police = 1'b0;
    cyc(1'b0);
    ticks(2);
    ticks(3);
    Reset = 1'b1;
    cyc(1'b1);
    n_tests++;
    if ({state, count, lamps} !== {3'd0, 8'd0, 8'h00}) begin
      n_fail++; $display("FAIL reset_mid_mg: got %0d/%0d/%b want 0/0/00000000", state, count, lamps);
    end
    Reset = 1'b0;
    cyc(1'b0);
    n_tests++;
    if ({state, count} !== {3'd6, 8'd2}) begin
      n_fail++; $display("FAIL after_reset: got %0d/%0d want 6/2", state, count);
    end
    $display("[TB] test_offline_and_reset done");
  endtask

  task automatic test_ped_main_gap;
    ticks(2);
    PQm = 1'b1; cyc(1'b0); PQm = 1'b0;
    ticks(30 + 3 + 2);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd20}) begin
      n_fail++; $display("FAIL pm_sg_entry: got %0d/%0d want 4/20", state, count);
    end
    ticks(5);
    n_tests++;
    if ({state, count} !== {3'd4, 8'd15}) begin
      n_fail++; $display("FAIL pm_sg_15: got %0d/%0d want 4/15", state, count);
    end
    ticks(1);
    n_tests++;
    if ({state, count} !== {3'd5, 8'd3}) begin
      n_fail++; $display("FAIL pm_gap_out: got %0d/%0d want 5/3", state, count);
    end
    $display("[TB] test_ped_main_gap done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_cycle();
    test_mg_rest_and_gap();
    test_av();
    test_police();
    test_offline_and_reset();
    test_ped_main_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
